// File: rtl/raster_scan_ctrl.sv
// Frame sequencer: gates one frame of a ready/valid pixel stream per start and
// tags every pixel with its column/row and line/frame boundary markers.
module raster_scan_ctrl #(
  parameter int width_p      = 640,
  parameter int height_p     = 480,
  parameter int data_width_p = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic                        start_i,
  input  logic                        abort_i,
  output logic                        busy_o,
  output logic                        done_o,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [data_width_p-1:0]     data_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [data_width_p-1:0]     data_o,
  output logic [$clog2(width_p)-1:0]  col_o,
  output logic [$clog2(height_p)-1:0] row_o,
  output logic                        sol_o,
  output logic                        eol_o,
  output logic                        sof_o,
  output logic                        eof_o
);

  localparam int col_w_lp = $clog2(width_p);
  localparam int row_w_lp = $clog2(height_p);
  localparam logic [col_w_lp-1:0] col_last_lp = col_w_lp'(width_p - 1);
  localparam logic [row_w_lp-1:0] row_last_lp = row_w_lp'(height_p - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e              state_q;
  logic [col_w_lp-1:0] col_q;
  logic [row_w_lp-1:0] row_q;
  logic                active;
  logic                col_last;
  logic                row_last;

  assign active   = (state_q == ACTIVE);
  assign col_last = (col_q == col_last_lp);
  assign row_last = (row_q == row_last_lp);

  // Abort wins over a coincident handshake, so that beat is never counted.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= ACTIVE;
            col_q   <= '0;
            row_q   <= '0;
          end
        end
        ACTIVE: begin
          if (abort_i) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
          end else if (valid_i && ready_i) begin
            if (col_last) begin
              col_q <= '0;
              if (row_last) begin
                row_q   <= '0;
                state_q <= DONE;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Zero-latency pass-through; outside ACTIVE both directions are held off.
  assign valid_o = active & valid_i;
  assign ready_o = active & ready_i;
  assign data_o  = data_i;

  assign busy_o = active;
  assign done_o = (state_q == DONE);
  assign col_o  = col_q;
  assign row_o  = row_q;

  assign sol_o = active & (col_q == '0);
  assign eol_o = active & col_last;
  assign sof_o = sol_o & (row_q == '0);
  assign eof_o = eol_o & row_last;

endmodule

// File: tb/tb_raster_scan_ctrl.sv
// Bench for raster_scan_ctrl on a 4x3 frame: boundary table plus scoreboarded
// stream under backpressure, abort, mid-frame reset and start handling.
module tb_raster_scan_ctrl;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int DW = 8;

  logic          clk_i = 1'b0;
  logic          reset_ni = 1'b0;
  logic          start_i = 1'b0, abort_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          busy_o, done_o, ready_o, valid_o;
  logic [DW-1:0] data_o;
  logic [1:0]    col_o, row_o;
  logic          sol_o, eol_o, sof_o, eof_o;

  raster_scan_ctrl #(.width_p(W), .height_p(H), .data_width_p(DW)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .col_o(col_o), .row_o(row_o), .sol_o(sol_o), .eol_o(eol_o),
    .sof_o(sof_o), .eof_o(eof_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int d; int col; int row; int sol; int eol; int sof; int eof;
  } exp_t;
  typedef struct {
    int col; int row; int sol; int eol; int sof; int eof;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[12];

  int n_chk = 0, n_fail = 0, n_beats = 0;
  int m_state = 0, mcol = 0, mrow = 0;
  int o_col, o_row, o_sol, o_eol, o_sof, o_eof, o_busy, o_done;

  task automatic check(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Scoreboard drain: every accepted downstream beat must match the oldest push.
  exp_t e_mon;
  always @(negedge clk_i) begin
    if (reset_ni === 1'b1 && valid_o === 1'b1 && ready_i && !abort_i) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_underflow: beat accepted with no expected entry (t=%0t)", $time);
      end else begin
        e_mon = sb.pop_front();
        check("sb_data", int'(data_o), e_mon.d);
        check("sb_col",  int'(col_o),  e_mon.col);
        check("sb_row",  int'(row_o),  e_mon.row);
        check("sb_sol",  int'(sol_o),  e_mon.sol);
        check("sb_eol",  int'(eol_o),  e_mon.eol);
        check("sb_sof",  int'(sof_o),  e_mon.sof);
        check("sb_eof",  int'(eof_o),  e_mon.eof);
        n_beats++;
      end
    end
  end

  // One clock cycle: drive, push expectation, observe at negedge, advance model.
  task automatic cyc(input bit s, input bit a, input bit v, input bit r, input int d);
    exp_t e;
    start_i = s; abort_i = a; valid_i = v; ready_i = r; data_i = DW'(d);
    if (m_state == 1 && v && r && !a) begin
      e.d = d & 8'hff; e.col = mcol; e.row = mrow;
      e.sol = int'(mcol == 0); e.eol = int'(mcol == W-1);
      e.sof = int'(mcol == 0 && mrow == 0); e.eof = int'(mcol == W-1 && mrow == H-1);
      sb.push_back(e);
    end
    @(negedge clk_i);
    o_col = int'(col_o); o_row = int'(row_o);
    o_sol = int'(sol_o); o_eol = int'(eol_o); o_sof = int'(sof_o); o_eof = int'(eof_o);
    o_busy = int'(busy_o); o_done = int'(done_o);
    check("busy_o",  o_busy, int'(m_state == 1));
    check("done_o",  o_done, int'(m_state == 2));
    check("valid_o", int'(valid_o), int'(m_state == 1 && v));
    check("ready_o", int'(ready_o), int'(m_state == 1 && r));
    if (!(m_state == 1 && v && r && !a)) begin
      check("col_hold", o_col, mcol);
      check("row_hold", o_row, mrow);
    end
    @(posedge clk_i); #1;
    case (m_state)
      0: if (s) begin m_state = 1; mcol = 0; mrow = 0; end
      1: begin
        if (a) begin
          m_state = 0; mcol = 0; mrow = 0;
        end else if (v && r) begin
          if (mcol == W-1) begin
            mcol = 0;
            if (mrow == H-1) begin mrow = 0; m_state = 2; end
            else mrow++;
          end else mcol++;
        end
      end
      default: m_state = 0;
    endcase
  endtask

  task automatic do_reset(input int n);
    reset_ni = 1'b0; start_i = 0; abort_i = 0; valid_i = 1; ready_i = 1;
    repeat (n) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      check("rst_busy",  int'(busy_o),  0);
      check("rst_done",  int'(done_o),  0);
      check("rst_valid", int'(valid_o), 0);
      check("rst_ready", int'(ready_o), 0);
      check("rst_col",   int'(col_o),   0);
      check("rst_row",   int'(row_o),   0);
    end
    reset_ni = 1'b1;
    m_state = 0; mcol = 0; mrow = 0;
    sb.delete();
    @(posedge clk_i); #1;
  endtask

  task automatic run_table();
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 1, 1, i * 7 + 3);
      check($sformatf("tbl%0d_col", i), o_col, tbl[i].col);
      check($sformatf("tbl%0d_row", i), o_row, tbl[i].row);
      check($sformatf("tbl%0d_sol", i), o_sol, tbl[i].sol);
      check($sformatf("tbl%0d_eol", i), o_eol, tbl[i].eol);
      check($sformatf("tbl%0d_sof", i), o_sof, tbl[i].sof);
      check($sformatf("tbl%0d_eof", i), o_eof, tbl[i].eof);
    end
    cyc(0, 0, 0, 0, 0);
    check("tbl_done_pulse", o_done, 1);
    cyc(0, 0, 0, 0, 0);
    check("tbl_after_done", o_done + o_busy, 0);
  endtask

  task automatic finish_frame(input string nm, input bit rnd);
    int k;
    bit v, r;
    k = 0;
    while (m_state == 1 && k < 400) begin
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc(0, 0, v, r, int'($urandom_range(0, 255)));
      k++;
    end
    if (m_state == 1) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: frame not finished after %0d cycles", nm, k);
    end
  endtask

  initial begin
    int b0, dones, gap, gap_seen, k;
    bit in_gap;
    tbl[0]  = '{0, 0, 1, 0, 1, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 0};
    tbl[2]  = '{2, 0, 0, 0, 0, 0};
    tbl[3]  = '{3, 0, 0, 1, 0, 0};
    tbl[4]  = '{0, 1, 1, 0, 0, 0};
    tbl[5]  = '{1, 1, 0, 0, 0, 0};
    tbl[6]  = '{2, 1, 0, 0, 0, 0};
    tbl[7]  = '{3, 1, 0, 1, 0, 0};
    tbl[8]  = '{0, 2, 1, 0, 0, 0};
    tbl[9]  = '{1, 2, 0, 0, 0, 0};
    tbl[10] = '{2, 2, 0, 0, 0, 0};
    tbl[11] = '{3, 2, 0, 1, 0, 1};

    do_reset(3);
    repeat (2) cyc(0, 0, 1, 1, 8'h55);

    run_table();

    // Random valid/ready over a whole frame.
    b0 = n_beats;
    cyc(1, 0, 0, 0, 0);
    finish_frame("bp", 1'b1);
    cyc(0, 0, 0, 0, 0);
    check("bp_beats", n_beats - b0, 12);
    check("bp_sb_empty", sb.size(), 0);

    // Abort together with a beat at row 1, col 2.
    cyc(1, 0, 0, 0, 0);
    repeat (6) cyc(0, 0, 1, 1, int'($urandom_range(0, 255)));
    cyc(0, 1, 1, 1, 8'hee);
    check("abort_col", o_col, 2);
    check("abort_row", o_row, 1);
    cyc(0, 0, 0, 0, 0);
    check("abort_idle", o_busy + o_done + o_col + o_row, 0);
    run_table();

    // Reset after 5 beats.
    cyc(1, 0, 0, 0, 0);
    repeat (5) cyc(0, 0, 1, 1, int'($urandom_range(0, 255)));
    do_reset(1);
    cyc(0, 0, 1, 1, 0);
    check("mrst_idle", o_busy + o_done + o_col + o_row, 0);

    // Start during ACTIVE is ignored.
    cyc(1, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 1, 1, int'($urandom_range(0, 255)));
    cyc(1, 0, 0, 0, 0);
    check("ign_start_col", o_col, 3);
    cyc(1, 0, 1, 1, 8'h3c);
    finish_frame("ign", 1'b0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Start held high across two frames.
    b0 = n_beats; dones = 0; gap = 0; gap_seen = -1; in_gap = 0; k = 0;
    while (dones < 2 && k < 100) begin
      cyc(1, 0, 1, 1, int'($urandom_range(0, 255)));
      if (o_done == 1) begin dones++; in_gap = (dones == 1); end
      if (in_gap) begin
        if (o_busy == 0) gap++;
        else begin gap_seen = gap; in_gap = 0; end
      end
      k++;
    end
    cyc(0, 0, 0, 0, 0);
    check("held_dones", dones, 2);
    check("held_gap", gap_seen, 2);
    check("held_beats", n_beats - b0, 24);
    check("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/raster_scan_ctrl.md
Name: raster_scan_ctrl

Overview:
- Frame sequencer for the pixel stream between the camera capture front-end and the vision filters.
- Owns the column and row counters and gates a ready/valid pixel stream for exactly one frame per start command.
- Tags each pixel with its position and with start/end-of-line and start/end-of-frame markers, then reports frame completion.
- Filters downstream use the markers for line buffering and window boundaries.

Parameters:
- width_p, 640, active pixels per line (>= 2).
- height_p, 480, lines per frame (>= 2).
- data_width_p, 8, pixel data width in bits.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_ni  input  1  synchronous, active-low reset.
- start_i  input  1  begin one frame; honoured only in IDLE.
- abort_i  input  1  terminate the current frame; honoured only in ACTIVE.
- busy_o  output  1  high while in ACTIVE.
- done_o  output  1  single-cycle pulse after the last pixel of a frame is accepted.
- valid_i  input  1  upstream pixel valid.
- ready_o  output  1  upstream ready.
- data_i  input  data_width_p  upstream pixel.
- valid_o  output  1  downstream pixel valid.
- ready_i  input  1  downstream ready.
- data_o  output  data_width_p  downstream pixel.
- col_o  output  $clog2(width_p)  column of the current pixel.
- row_o  output  $clog2(height_p)  row of the current pixel.
- sol_o, eol_o  output  1 each  current pixel is first / last in its line.
- sof_o, eof_o  output  1 each  current pixel is first / last in the frame.

Behaviour:
- Reset: reset_ni low at a rising edge forces state IDLE and col = row = 0.
  - While in IDLE after reset: busy_o = done_o = valid_o = ready_o = 0.
  - Reset takes priority over every other input, including mid-frame; a frame in progress is dropped with no done_o.
- FSM states: IDLE, ACTIVE, DONE.
  - IDLE -> ACTIVE when start_i = 1; col and row are cleared on the same edge.
  - ACTIVE -> IDLE when abort_i = 1. abort_i has priority over a coincident handshake: that beat is not counted and no done_o is produced.
  - ACTIVE -> DONE on the handshake of the pixel at col = width_p-1 and row = height_p-1.
  - DONE -> IDLE unconditionally after one cycle.
- Gating:
  - ACTIVE: valid_o = valid_i, ready_o = ready_i, data_o = data_i. The path is combinational, with zero latency and no buffering.
  - IDLE and DONE: valid_o = 0 and ready_o = 0, so upstream stalls. data_o is don't-care but must be driven (data_i is acceptable).
- Handshake: a beat occurs when in ACTIVE with valid_i = 1, ready_i = 1 and abort_i = 0. Counters change only on a beat.
  - If col < width_p-1: col increments by 1.
  - Otherwise col wraps to 0 and row increments by 1.
  - On the final beat (col = width_p-1, row = height_p-1), col and row both return to 0.
- Holding: valid_i = 1 with ready_i = 0 holds counters and markers, and the pixel stays presented. A stalled pixel is never skipped or double-counted.
- Markers are combinational from the counters and qualified by ACTIVE (0 elsewhere):
  - sol_o = (col == 0); eol_o = (col == width_p-1).
  - sof_o = sol_o & (row == 0); eof_o = eol_o & (row == height_p-1).
- col_o and row_o always show the counter registers (0 in IDLE).
- busy_o = (state == ACTIVE); done_o = (state == DONE).
- start_i asserted in ACTIVE or DONE is ignored, not queued. A start_i held high through DONE starts the next frame on the first IDLE cycle, so back-to-back frames have a 2-cycle gap.
- Arithmetic:
  - Counters are unsigned. Comparisons use width-matched constants (width_p-1 and height_p-1 cast to the counter width).
  - No wrap-around occurs beyond those limits.

Test Plan:
- Reset and idle: hold reset_ni = 0 for 3 cycles with valid_i = ready_i = 1, then release with start_i = 0 -> ready_o = valid_o = busy_o = 0 and col_o = row_o = 0 throughout.
- Full frame (width_p = 4, height_p = 3): pulse start_i, stream 12 beats back-to-back.
  - Beat 0: sof_o = 1.
  - Beats 3, 7, 11: eol_o = 1.
  - Beats 4 and 8: sol_o = 1 with row_o = 1 and 2.
  - Beat 11: eof_o = 1.
  - done_o pulses the cycle after beat 11; the next cycle is IDLE.
- Backpressure: randomly toggle valid_i and ready_i at ~50% during a 4x3 frame -> data_o matches a scoreboard of accepted data_i in order, exactly 12 beats are counted, and col/row hold on every stall.
- Abort: at row = 1, col = 2, assert abort_i together with a beat -> next cycle IDLE with col = row = 0, no done_o; a fresh start_i then yields a full 12-beat frame starting with sof_o.
- Reset mid-frame: drop reset_ni after 5 beats -> next cycle IDLE with counters 0, no done_o.
- Ignored and held start: pulse start_i during ACTIVE -> no counter change. Then hold start_i high across two frames -> done_o pulses twice, with exactly 2 non-ACTIVE cycles between the frames.
